alu_arbiter: RTL and testbench

Shares the single combinational integer ALU between two requesters (req0: integer pipeline execute stage, req1: address/CSR helper unit) using round-robin arbitration. The block drives the ALU operands, captures its result, zero and carry outputs into a one-entry response register, and returns the result with a valid/ready handshake tagged with the requester id. It sits between the requesters and the ALU instance and is the only driver of the ALU inputs.

---
 rtl/alu_arbiter.sv | 118 +++++++++++
 tb/tb_alu_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// capturing each result into a single-entry response register.
module alu_arbiter #(
   parameter bit INIT_PRIO = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [2:0]  req0_opcode,
   input  logic        req0_sub,
   input  logic [31:0] req0_op1,
   input  logic [31:0] req0_op2,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [2:0]  req1_opcode,
   input  logic        req1_sub,
   input  logic [31:0] req1_op1,
   input  logic [31:0] req1_op2,
   output logic [2:0]  alu_opcode,
   output logic        alu_sub,
   output logic [31:0] alu_op1,
   output logic [31:0] alu_op2,
   input  logic [31:0] alu_out,
   input  logic        alu_z,
   input  logic        alu_c,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_data,
   output logic        rsp_z,
   output logic        rsp_c
);

   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_id_q, rsp_id_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   logic        rsp_z_q, rsp_z_d;
   logic        rsp_c_q, rsp_c_d;
   logic        prio_q, prio_d;

   logic slot_free;
   logic grant0;
   logic grant1;

   // Grants depend only on valids, the response slot and prio, never on alu_out.
   always_comb begin
      slot_free = !rsp_valid_q || rsp_ready;
      grant0    = !rst && slot_free && req0_valid && (!req1_valid || !prio_q);
      grant1    = !rst && slot_free && req1_valid && (!req0_valid ||  prio_q);
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   always_comb begin
      alu_opcode = 3'b000;
      alu_sub    = 1'b0;
      alu_op1    = 32'd0;
      alu_op2    = 32'd0;
      if (grant0) begin
         alu_opcode = req0_opcode;
         alu_sub    = req0_sub;
         alu_op1    = req0_op1;
         alu_op2    = req0_op2;
      end else if (grant1) begin
         alu_opcode = req1_opcode;
         alu_sub    = req1_sub;
         alu_op1    = req1_op1;
         alu_op2    = req1_op2;
      end
   end

   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      rsp_z_d     = rsp_z_q;
      rsp_c_d     = rsp_c_q;
      prio_d      = prio_q;
      if (grant0 || grant1) begin
         rsp_valid_d = 1'b1;
         rsp_id_d    = grant1;
         rsp_data_d  = alu_out;
         rsp_z_d     = alu_z;
         // Carry is only meaningful for ADD/SUB; the ALU may drive junk otherwise.
         rsp_c_d     = (alu_opcode == 3'b000) ? alu_c : 1'b0;
         prio_d      = !grant1;
      end else if (slot_free) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_data_q  <= 32'd0;
         rsp_z_q     <= 1'b0;
         rsp_c_q     <= 1'b0;
         prio_q      <= INIT_PRIO;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         rsp_z_q     <= rsp_z_d;
         rsp_c_q     <= rsp_c_d;
         prio_q      <= prio_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_z     = rsp_z_q;
   assign rsp_c     = rsp_c_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: stimulus pushes hand-computed responses into a
// scoreboard queue, a negedge monitor pops and compares on each accepted response.
module tb_alu_arbiter;

   typedef struct packed {
      logic        id;
      logic [31:0] data;
      logic        z;
      logic        c;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready, req0_sub;
   logic [2:0]  req0_opcode;
   logic [31:0] req0_op1, req0_op2;
   logic        req1_valid, req1_ready, req1_sub;
   logic [2:0]  req1_opcode;
   logic [31:0] req1_op1, req1_op2;
   logic [2:0]  alu_opcode;
   logic        alu_sub;
   logic [31:0] alu_op1, alu_op2;
   logic [31:0] alu_out;
   logic        alu_z, alu_c;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_z, rsp_c;
   logic [31:0] rsp_data;

   int   checks   = 0;
   int   failures = 0;
   rsp_t sb[$];

   always #5 clk = ~clk;

   alu_arbiter #(.INIT_PRIO(1'b0)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
      .req0_sub(req0_sub), .req0_op1(req0_op1), .req0_op2(req0_op2),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
      .req1_sub(req1_sub), .req1_op1(req1_op1), .req1_op2(req1_op2),
      .alu_opcode(alu_opcode), .alu_sub(alu_sub), .alu_op1(alu_op1), .alu_op2(alu_op2),
      .alu_out(alu_out), .alu_z(alu_z), .alu_c(alu_c),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_z(rsp_z), .rsp_c(rsp_c)
   );

   // Reference ALU; carry is deliberately 1 for non-ADD ops so masking is observable.
   always_comb begin
      logic [32:0] wide;
      wide    = 33'd0;
      alu_out = 32'd0;
      alu_c   = 1'b1;
      case (alu_opcode)
         3'b000: begin
            if (alu_sub) wide = {1'b0, alu_op1} - {1'b0, alu_op2};
            else         wide = {1'b0, alu_op1} + {1'b0, alu_op2};
            alu_out = wide[31:0];
            alu_c   = wide[32];
         end
         3'b001: alu_out = alu_op1 << alu_op2[4:0];
         3'b010: alu_out = {31'd0, $signed(alu_op1) < $signed(alu_op2)};
         3'b011: alu_out = {31'd0, alu_op1 < alu_op2};
         3'b100: alu_out = alu_op1 ^ alu_op2;
         3'b101: alu_out = alu_sub ? 32'($signed(alu_op1) >>> alu_op2[4:0])
                                   : alu_op1 >> alu_op2[4:0];
         3'b110: alu_out = alu_op1 | alu_op2;
         default: alu_out = alu_op1 & alu_op2;
      endcase
      alu_z = (alu_out == 32'd0);
   end

   function automatic rsp_t mk(input logic id, input logic [31:0] d, input logic z, input logic c);
      rsp_t r;
      r.id = id; r.data = d; r.z = z; r.c = c;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic set0(input logic v, input logic [2:0] op, input logic s,
                       input logic [31:0] a, input logic [31:0] b);
      req0_valid = v; req0_opcode = op; req0_sub = s; req0_op1 = a; req0_op2 = b;
   endtask

   task automatic set1(input logic v, input logic [2:0] op, input logic s,
                       input logic [31:0] a, input logic [31:0] b);
      req1_valid = v; req1_opcode = op; req1_sub = s; req1_op1 = a; req1_op2 = b;
   endtask

   // Called at posedge+1 with inputs set; checks readies before the negedge.
   task automatic tick(input logic e0, input logic e1, input logic push, input rsp_t exp);
      #3;
      chk("req0_ready", {31'd0, req0_ready}, {31'd0, e0});
      chk("req1_ready", {31'd0, req1_ready}, {31'd0, e1});
      if (push) sb.push_back(exp);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL rsp unexpected id=%0d data=%h z=%0d c=%0d", rsp_id, rsp_data, rsp_z, rsp_c);
         end else begin
            rsp_t e;
            e = sb.pop_front();
            if ({rsp_id, rsp_data, rsp_z, rsp_c} !== e) begin
               failures++;
               $display("FAIL rsp got id=%0d data=%h z=%0d c=%0d exp id=%0d data=%h z=%0d c=%0d",
                        rsp_id, rsp_data, rsp_z, rsp_c, e.id, e.data, e.z, e.c);
            end else begin
               $display("rsp ok id=%0d data=%h z=%0d c=%0d", rsp_id, rsp_data, rsp_z, rsp_c);
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      rsp_ready = 1'b1;
      set0(1'b0, 3'b000, 1'b0, 32'd0, 32'd0);
      set1(1'b0, 3'b000, 1'b0, 32'd0, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("reset rsp_id", {31'd0, rsp_id}, 32'd0);
      chk("reset rsp_data", rsp_data, 32'd0);
      chk("reset rsp_z", {31'd0, rsp_z}, 32'd0);
      chk("reset rsp_c", {31'd0, rsp_c}, 32'd0);
      rst = 1'b0;

      // Single-requester operations
      set0(1'b1, 3'b000, 1'b0, 32'd5, 32'd3);
      tick(1'b1, 1'b0, 1'b1, mk(1'b0, 32'd8, 1'b0, 1'b0));
      chk("latency rsp_valid", {31'd0, rsp_valid}, 32'd1);
      set0(1'b0, 3'b000, 1'b0, 32'd0, 32'd0);
      set1(1'b1, 3'b000, 1'b1, 32'd3, 32'd5);
      tick(1'b0, 1'b1, 1'b1, mk(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1));
      set1(1'b1, 3'b100, 1'b0, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
      tick(1'b0, 1'b1, 1'b1, mk(1'b1, 32'd0, 1'b1, 1'b0));

      // Both valid: strict alternation starting from requester 0
      set0(1'b1, 3'b000, 1'b0, 32'hFFFF_FFFF, 32'd1);
      set1(1'b1, 3'b110, 1'b0, 32'h0000_00F0, 32'h0000_000F);
      tick(1'b1, 1'b0, 1'b1, mk(1'b0, 32'd0, 1'b1, 1'b1));
      set0(1'b1, 3'b001, 1'b0, 32'd1, 32'd31);
      tick(1'b0, 1'b1, 1'b1, mk(1'b1, 32'h0000_00FF, 1'b0, 1'b0));
      set1(1'b1, 3'b111, 1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0);
      tick(1'b1, 1'b0, 1'b1, mk(1'b0, 32'h8000_0000, 1'b0, 1'b0));
      tick(1'b0, 1'b1, 1'b1, mk(1'b1, 32'h0F00_0F00, 1'b0, 1'b0));

      // Backpressure: response held, no grants
      rsp_ready = 1'b0;
      set0(1'b1, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1);
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, 1'b0, 1'b0, mk(1'b0, 32'd0, 1'b0, 1'b0));
         chk("stall rsp_valid", {31'd0, rsp_valid}, 32'd1);
         chk("stall rsp_data", rsp_data, 32'h0F00_0F00);
      end
      rsp_ready = 1'b1;
      tick(1'b1, 1'b0, 1'b1, mk(1'b0, 32'd1, 1'b0, 1'b0));
      set1(1'b0, 3'b000, 1'b0, 32'd0, 32'd0);
      set0(1'b1, 3'b101, 1'b1, 32'h8000_0000, 32'd4);
      tick(1'b1, 1'b0, 1'b1, mk(1'b0, 32'hF800_0000, 1'b0, 1'b0));
      set0(1'b1, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1);
      tick(1'b1, 1'b0, 1'b1, mk(1'b0, 32'd0, 1'b1, 1'b0));

      // Reset while a response is held; prio is 1 here, INIT_PRIO is 0
      rsp_ready = 1'b0;
      set0(1'b1, 3'b000, 1'b0, 32'd7, 32'd9);
      set1(1'b1, 3'b000, 1'b0, 32'd100, 32'd1);
      tick(1'b0, 1'b0, 1'b0, mk(1'b0, 32'd0, 1'b0, 1'b0));
      chk("held rsp_valid", {31'd0, rsp_valid}, 32'd1);
      rst = 1'b1;
      tick(1'b0, 1'b0, 1'b0, mk(1'b0, 32'd0, 1'b0, 1'b0));
      sb.delete();
      rst = 1'b0;
      chk("post-rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("post-rst rsp_data", rsp_data, 32'd0);
      rsp_ready = 1'b1;
      tick(1'b1, 1'b0, 1'b1, mk(1'b0, 32'd16, 1'b0, 1'b0));

      // Idle: no grant drives ADD 0+0 to the ALU
      set0(1'b0, 3'b000, 1'b0, 32'd0, 32'd0);
      set1(1'b0, 3'b111, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF);
      #3;
      chk("idle req0_ready", {31'd0, req0_ready}, 32'd0);
      chk("idle req1_ready", {31'd0, req1_ready}, 32'd0);
      chk("idle alu_opcode", {29'd0, alu_opcode}, 32'd0);
      chk("idle alu_sub", {31'd0, alu_sub}, 32'd0);
      chk("idle alu_op1", alu_op1, 32'd0);
      chk("idle alu_op2", alu_op2, 32'd0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
      #1;
      chk("scoreboard drained", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
